// File: rtl/mdc_delay_commutator_pkg.sv
// Shared types and constants for the 32-point MDC FFT delay-commutator stages.
package mdc_delay_commutator_pkg;

  localparam int unsigned SAMPLE_W   = 9;
  localparam int unsigned FFT_POINTS = 32;
  localparam int unsigned NUM_STAGES = 5;

  localparam logic MODE_REORDER = 1'b0;
  localparam logic MODE_BYPASS  = 1'b1;

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] re;
    logic signed [SAMPLE_W-1:0] im;
  } cplx_t;

  // Stage 1 delays by 16, halving each stage down to 1 at stage 5.
  function automatic int unsigned stage_depth(input int unsigned stage);
    return FFT_POINTS >> stage;
  endfunction

  // Sample counter spans one 2*DEPTH block; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(2 * depth);
  endfunction

endpackage

// File: rtl/mdc_delay_line.sv
// Enabled shift register delaying a complex sample by DEPTH accepted samples.
module mdc_delay_line #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [2*WIDTH-1:0] din,
  output logic [2*WIDTH-1:0] dout
);

  localparam int unsigned DATA_W = 2 * WIDTH;

  logic [DEPTH-1:0][DATA_W-1:0] taps;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taps <= '0;
    end else if (en) begin
      taps[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        taps[i] <= taps[i-1];
      end
    end
  end

  assign dout = taps[DEPTH-1];

endmodule

// File: rtl/mdc_delay_commutator.sv
// Delay-switch-delay reorder unit between two MDC FFT butterfly stages,
// with its own sample counter, fill tracking and a registered bypass path.
module mdc_delay_commutator
  import mdc_delay_commutator_pkg::*;
#(
  parameter int unsigned WIDTH = SAMPLE_W,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_up_re,
  input  logic [WIDTH-1:0] in_up_im,
  input  logic [WIDTH-1:0] in_low_re,
  input  logic [WIDTH-1:0] in_low_im,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_up_re,
  output logic [WIDTH-1:0] out_up_im,
  output logic [WIDTH-1:0] out_low_re,
  output logic [WIDTH-1:0] out_low_im
);

  localparam int unsigned CNT_W  = cnt_width(DEPTH);
  localparam int unsigned FILL_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [WIDTH-1:0] re;
    logic [WIDTH-1:0] im;
  } sample_t;

  logic             mode_q;
  logic [CNT_W-1:0] cnt_q;
  logic [FILL_W-1:0] fill_q;

  logic              mode_chg_c;
  logic [CNT_W-1:0]  cnt_cur_c;
  logic [FILL_W-1:0] fill_cur_c;
  logic              shift_en_c;
  logic              swap_c;
  sample_t           up_c;
  sample_t           low_c;
  sample_t           pre_out_c;
  sample_t           post_out_c;
  sample_t           p_c;
  sample_t           q_c;

  // A mode change restarts sample numbering on this very edge.
  assign mode_chg_c = (mode != mode_q);
  assign cnt_cur_c  = mode_chg_c ? '0 : cnt_q;
  assign fill_cur_c = mode_chg_c ? '0 : fill_q;
  assign shift_en_c = in_valid && (mode == MODE_REORDER);
  assign swap_c     = cnt_cur_c[CNT_W-1];

  assign up_c  = '{re: in_up_re,  im: in_up_im};
  assign low_c = '{re: in_low_re, im: in_low_im};

  // Path swap between the two delay lines.
  assign p_c = swap_c ? pre_out_c : up_c;
  assign q_c = swap_c ? up_c      : pre_out_c;

  mdc_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_pre_delay (
    .clk  (clk),
    .rst  (rst),
    .en   (shift_en_c),
    .din  (low_c),
    .dout (pre_out_c)
  );

  mdc_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_post_delay (
    .clk  (clk),
    .rst  (rst),
    .en   (shift_en_c),
    .din  (p_c),
    .dout (post_out_c)
  );

  // Counter, fill tracking and output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q     <= MODE_REORDER;
      cnt_q      <= '0;
      fill_q     <= '0;
      out_valid  <= 1'b0;
      out_up_re  <= '0;
      out_up_im  <= '0;
      out_low_re <= '0;
      out_low_im <= '0;
    end else begin
      mode_q    <= mode;
      out_valid <= 1'b0;
      if (mode == MODE_BYPASS) begin
        cnt_q     <= '0;
        fill_q    <= '0;
        out_valid <= in_valid;
        if (in_valid) begin
          out_up_re  <= in_up_re;
          out_up_im  <= in_up_im;
          out_low_re <= in_low_re;
          out_low_im <= in_low_im;
        end
      end else begin
        cnt_q  <= cnt_cur_c;
        fill_q <= fill_cur_c;
        if (in_valid) begin
          cnt_q     <= cnt_cur_c + CNT_W'(1);
          out_valid <= (fill_cur_c == FILL_W'(DEPTH));
          if (fill_cur_c != FILL_W'(DEPTH)) begin
            fill_q <= fill_cur_c + FILL_W'(1);
          end
          {out_up_re, out_up_im}   <= post_out_c;
          {out_low_re, out_low_im} <= q_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_mdc_delay_commutator.sv
// Bench for mdc_delay_commutator: all five stage depths run side by side on
// shared stimulus and are checked against a pair-ordering reference model.
module tb_mdc_delay_commutator;
  import mdc_delay_commutator_pkg::*;

  localparam int unsigned NI = NUM_STAGES;

  logic clk;
  logic rst;
  logic mode;
  logic in_valid;
  logic [SAMPLE_W-1:0] in_up_re, in_up_im, in_low_re, in_low_im;
  logic [36:0] obs [NI];

  int errors;
  int checks;
  int cyc;

  // Reference model state: accepted samples of the current reorder session.
  cplx_t ups[$];
  cplx_t lows[$];
  logic  prev_mode;
  logic [36:0] exp_obs [NI];
  logic [36:0] exp_msk [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic ov;
    logic [SAMPLE_W-1:0] our, oui, olr, oli;
    mdc_delay_commutator #(.WIDTH(SAMPLE_W), .DEPTH(stage_depth(g + 1))) dut (
      .clk        (clk),
      .rst        (rst),
      .mode       (mode),
      .in_valid   (in_valid),
      .in_up_re   (in_up_re),
      .in_up_im   (in_up_im),
      .in_low_re  (in_low_re),
      .in_low_im  (in_low_im),
      .out_valid  (ov),
      .out_up_re  (our),
      .out_up_im  (oui),
      .out_low_re (olr),
      .out_low_im (oli)
    );
    assign obs[g] = {ov, our, oui, olr, oli};
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic cplx_t mk(input int re, input int im);
    cplx_t c;
    c.re = 9'(re);
    c.im = 9'(im);
    return c;
  endfunction

  function automatic cplx_t rnd();
    return mk(int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 511)) - 256);
  endfunction

  function automatic cplx_t rnd_ext();
    return mk(($urandom_range(0, 1) != 0) ? 255 : -256, ($urandom_range(0, 1) != 0) ? 255 : -256);
  endfunction

  task automatic model_reset();
    ups.delete();
    lows.delete();
    prev_mode = 1'b0;
    for (int k = 0; k < NI; k++) begin
      exp_obs[k] = '0;
      exp_msk[k] = '1;
    end
  endtask

  // Reorder rule: once DEPTH samples are in, the second half of each block
  // pairs upper samples DEPTH apart, the first half pairs lower samples.
  task automatic model_step(input logic m, input logic v, input cplx_t u, input cplx_t l);
    int t;
    int d;
    if (m != prev_mode) begin
      ups.delete();
      lows.delete();
    end
    prev_mode = m;
    if (!v) begin
      for (int k = 0; k < NI; k++) exp_obs[k][36] = 1'b0;
    end else if (m) begin
      ups.delete();
      lows.delete();
      for (int k = 0; k < NI; k++) begin
        exp_obs[k] = {1'b1, u, l};
        exp_msk[k] = '1;
      end
    end else begin
      ups.push_back(u);
      lows.push_back(l);
      t = ups.size() - 1;
      for (int k = 0; k < NI; k++) begin
        d = int'(stage_depth(k + 1));
        exp_msk[k] = '1;
        if (t < d) begin
          exp_obs[k] = '0;
          exp_msk[k] = {1'b1, 36'd0};
        end else if ((t % (2 * d)) >= d) begin
          exp_obs[k] = {1'b1, ups[t-d], ups[t]};
        end else begin
          exp_obs[k] = {1'b1, lows[t-2*d], lows[t-d]};
        end
      end
    end
  endtask

  task automatic drive(input logic m, input logic v, input cplx_t u, input cplx_t l);
    mode      = m;
    in_valid  = v;
    in_up_re  = u.re;
    in_up_im  = u.im;
    in_low_re = l.re;
    in_low_im = l.im;
    @(posedge clk);
    #1;
    cyc++;
    model_step(m, v, u, l);
  endtask

  task automatic apply_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    mode = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (obs[k] !== 37'd0) begin
        errors++;
        $display("FAIL reset D=%0d got=%h exp=0", stage_depth(k + 1), obs[k]);
      end
    end
    in_valid = 1'b0;
    mode = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_basic_reorder();
    int exp_u [6] = '{0, 0, 1, 2, 11, 12};
    int exp_l [6] = '{0, 0, 3, 4, 13, 14};
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      if (i < 6) drive(1'b0, 1'b1, mk(i + 1, i), mk(i + 11, -i));
      else       drive(1'b0, 1'b1, rnd(), rnd());
      for (int k = 0; k < NI; k++) begin
        checks++;
        if ((obs[k] & exp_msk[k]) !== (exp_obs[k] & exp_msk[k])) begin
          errors++;
          $display("FAIL basic_reorder D=%0d cyc=%0d got=%h exp=%h", stage_depth(k + 1), cyc, obs[k], exp_obs[k]);
        end
      end
      if (i >= 2 && i < 6) begin
        checks++;
        if (obs[3][36] !== 1'b1 || obs[3][35:27] !== 9'(exp_u[i]) || obs[3][17:9] !== 9'(exp_l[i])) begin
          errors++;
          $display("FAIL basic_pair_d2 i=%0d got v=%0b up=%0d low=%0d exp up=%0d low=%0d",
                   i, obs[3][36], obs[3][35:27], obs[3][17:9], exp_u[i], exp_l[i]);
        end
      end
    end
  endtask

  task automatic test_bubbles();
    apply_reset();
    for (int i = 0; i < 80; i++) begin
      if (i % 2 == 1)  drive(1'b0, 1'b0, rnd(), rnd());
      else if (i < 12) drive(1'b0, 1'b1, mk(i / 2 + 1, 0), mk(i / 2 + 11, 0));
      else             drive(1'b0, ($urandom_range(0, 2) != 0), rnd(), rnd());
      for (int k = 0; k < NI; k++) begin
        checks++;
        if ((obs[k] & exp_msk[k]) !== (exp_obs[k] & exp_msk[k])) begin
          errors++;
          $display("FAIL bubbles D=%0d cyc=%0d got=%h exp=%h", stage_depth(k + 1), cyc, obs[k], exp_obs[k]);
        end
      end
    end
  endtask

  task automatic test_bypass();
    for (int i = 0; i < 30; i++) begin
      if (i == 0) drive(1'b1, 1'b1, mk(5, -7), mk(-7, 5));
      else        drive(1'b1, ($urandom_range(0, 3) != 0), rnd(), rnd());
      if (i == 0) begin
        checks++;
        if (obs[1][36] !== 1'b1 || obs[1][35:27] !== 9'd5 || obs[1][26:18] !== 9'h1F9) begin
          errors++;
          $display("FAIL bypass_first got v=%0b up=(%0d,%0d) exp v=1 up=(5,-7)",
                   obs[1][36], $signed(obs[1][35:27]), $signed(obs[1][26:18]));
        end
      end
      for (int k = 0; k < NI; k++) begin
        checks++;
        if ((obs[k] & exp_msk[k]) !== (exp_obs[k] & exp_msk[k])) begin
          errors++;
          $display("FAIL bypass D=%0d cyc=%0d got=%h exp=%h", stage_depth(k + 1), cyc, obs[k], exp_obs[k]);
        end
      end
    end
  endtask

  task automatic test_mode_switch();
    logic m;
    apply_reset();
    m = 1'b0;
    for (int i = 0; i < 330; i++) begin
      if (i < 3)       m = 1'b0;
      else if (i < 7)  m = 1'b1;
      else if (i < 32) m = 1'b0;
      else if ($urandom_range(0, 15) == 0) m = ~m;
      drive(m, (i < 32) || ($urandom_range(0, 3) != 0), rnd(), rnd());
      for (int k = 0; k < NI; k++) begin
        checks++;
        if ((obs[k] & exp_msk[k]) !== (exp_obs[k] & exp_msk[k])) begin
          errors++;
          $display("FAIL mode_switch D=%0d cyc=%0d got=%h exp=%h", stage_depth(k + 1), cyc, obs[k], exp_obs[k]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 0; i < 21; i++) drive(1'b0, 1'b1, rnd(), rnd());
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (obs[k] !== 37'd0) begin
        errors++;
        $display("FAIL async_reset D=%0d got=%h exp=0", stage_depth(k + 1), obs[k]);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 45; i++) begin
      drive(1'b0, 1'b1, rnd(), rnd());
      for (int k = 0; k < NI; k++) begin
        checks++;
        if ((obs[k] & exp_msk[k]) !== (exp_obs[k] & exp_msk[k])) begin
          errors++;
          $display("FAIL after_reset D=%0d cyc=%0d got=%h exp=%h", stage_depth(k + 1), cyc, obs[k], exp_obs[k]);
        end
      end
    end
  endtask

  task automatic test_wrap_extremes();
    apply_reset();
    for (int i = 0; i < 1000; i++) begin
      drive(1'b0, ($urandom_range(0, 7) != 0), rnd_ext(), rnd_ext());
      for (int k = 0; k < NI; k++) begin
        checks++;
        if ((obs[k] & exp_msk[k]) !== (exp_obs[k] & exp_msk[k])) begin
          errors++;
          $display("FAIL wrap_extremes D=%0d cyc=%0d got=%h exp=%h", stage_depth(k + 1), cyc, obs[k], exp_obs[k]);
        end
      end
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    cyc       = 0;
    rst       = 1'b1;
    mode      = 1'b0;
    in_valid  = 1'b0;
    in_up_re  = '0;
    in_up_im  = '0;
    in_low_re = '0;
    in_low_im = '0;
    model_reset();
    test_reset();
    test_basic_reorder();
    test_bubbles();
    test_bypass();
    test_mode_switch();
    test_async_reset();
    test_wrap_extremes();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
